// File: rtl/mont_sched_pkg.sv
// mont_sched_pkg -- shared definitions for the Montgomery job scheduler.
//   PKG_NW    : default operand/modulus width (matches the Montgomery core)
//   PKG_NREQ  : default number of requester ports
//   CNT_W     : width of the core-latency counter / last_cycles
//   state_t   : scheduler FSM state encoding
//   sat_inc   : saturating increment for the latency counter
package mont_sched_pkg;

    localparam int PKG_NW   = 381;
    localparam int PKG_NREQ = 2;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_RESP  = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mont_sched_if.sv
// mont_sched_if -- requester-side bus of the Montgomery scheduler.
//   req_valid/req_ready : per-port job handshake (transfer on valid & ready)
//   req_a/req_b         : per-port operands, port i at [i*NW +: NW]
//   m_cfg               : shared modulus
//   rsp_valid/rsp_ready : per-port result handshake
//   rsp_data            : result of the job whose rsp_valid is high
// Modports: master = requesters, slave = scheduler.
interface mont_sched_if
    import mont_sched_pkg::*;
#(
    parameter int NW   = PKG_NW,
    parameter int NREQ = PKG_NREQ
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*NW-1:0] req_a;
    logic [NREQ*NW-1:0] req_b;
    logic [NW-1:0]      m_cfg;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [NW-1:0]      rsp_data;

    modport master (
        output req_valid, req_a, req_b, m_cfg, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, m_cfg, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mont_rr_pick.sv
// mont_rr_pick -- combinational round-robin pick.
//   i_req   : request vector
//   i_prio  : index of the port holding highest priority
//   o_grant : one-hot grant (all zero when no request)
module mont_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_prio,
    output logic [NREQ-1:0]  o_grant
);
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_rot_gnt;

    // Rotate so the priority port sits at bit 0, isolate the lowest set bit,
    // then rotate the winner back to its real position.
    assign w_rot     = NREQ'({i_req, i_req} >> i_prio);
    assign w_rot_gnt = w_rot & (~w_rot + NREQ'(1));
    assign o_grant   = NREQ'(({w_rot_gnt, w_rot_gnt} << i_prio) >> NREQ);
endmodule

// File: rtl/mont_sched.sv
// mont_sched -- arbitrates NREQ requesters onto one Montgomery core.
//   clk, rst       : clock, synchronous active-high reset
//   s_if           : requester bus (mont_sched_if.slave)
//   core_start     : one-cycle start pulse to the core
//   core_a/b/m     : operands held stable from grant to next grant
//   core_out_read  : result-read acknowledge to the core
//   core_result    : core result
//   core_done      : core result valid (level, held until out_read)
//   busy           : high whenever the FSM is not IDLE
//   last_cycles    : ISSUE-to-done core cycles of the last job, saturating
module mont_sched
    import mont_sched_pkg::*;
#(
    parameter int NW   = PKG_NW,
    parameter int NREQ = PKG_NREQ
) (
    input  logic             clk,
    input  logic             rst,
    mont_sched_if.slave      s_if,
    output logic             core_start,
    output logic [NW-1:0]    core_a,
    output logic [NW-1:0]    core_b,
    output logic [NW-1:0]    core_m,
    output logic             core_out_read,
    input  logic [NW-1:0]    core_result,
    input  logic             core_done,
    output logic             busy,
    output logic [CNT_W-1:0] last_cycles
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_prio, r_port, w_gidx;
    logic [NREQ-1:0]  w_grant, w_take;
    logic [CNT_W-1:0] r_cnt, r_last;
    logic [NW-1:0]    r_op_a, r_op_b, r_op_m, r_rsp_data;

    mont_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .i_req   (s_if.req_valid),
        .i_prio  (r_prio),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gidx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) w_gidx = IDX_W'(k);
        end
    end

    // A pending stale core result takes precedence over any new grant.
    assign w_take = (r_state == ST_IDLE && !core_done && !rst) ? w_grant : '0;

    assign s_if.req_ready = w_take;
    assign s_if.rsp_data  = r_rsp_data;
    assign core_a         = r_op_a;
    assign core_b         = r_op_b;
    assign core_m         = r_op_m;
    assign busy           = (r_state != ST_IDLE);
    assign last_cycles    = r_last;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
        assign s_if.rsp_valid[gi] = (r_state == ST_RESP) && (r_port == IDX_W'(gi));
    end

    always_comb begin
        w_state_next  = r_state;
        core_start    = 1'b0;
        core_out_read = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (core_done)               w_state_next = ST_FLUSH;
                else if (|s_if.req_valid)    w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Never start on top of a held result; drain it first.
                if (core_done) begin
                    core_out_read = 1'b1;
                end else begin
                    core_start   = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done) w_state_next = ST_READ;
            end
            ST_READ: begin
                core_out_read = 1'b1;
                w_state_next  = ST_RESP;
            end
            ST_RESP: begin
                if (s_if.rsp_ready[r_port]) w_state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                core_out_read = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_prio     <= '0;
            r_port     <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_m     <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (|w_take) begin
                r_port <= w_gidx;
                r_prio <= (w_gidx == IDX_W'(NREQ - 1)) ? '0 : w_gidx + IDX_W'(1);
                r_op_a <= s_if.req_a[w_gidx*NW +: NW];
                r_op_b <= s_if.req_b[w_gidx*NW +: NW];
                r_op_m <= s_if.m_cfg;
            end
            case (r_state)
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT:  r_cnt <= sat_inc(r_cnt);
                ST_READ: begin
                    r_rsp_data <= core_result;
                    r_last     <= r_cnt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_sched.sv
// tb_mont_sched -- directed self-checking bench for mont_sched.
// A behavioural core returns (a*b) % m a programmable number of cycles
// after core_start; monitors log grants, responses and core pulses.
`timescale 1ns/1ps
module tb_mont_sched;
    import mont_sched_pkg::*;

    localparam int NW   = PKG_NW;
    localparam int NREQ = PKG_NREQ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mont_sched_if #(.NW(NW), .NREQ(NREQ)) bus ();

    logic             core_start, core_out_read, core_done, busy;
    logic [NW-1:0]    core_a, core_b, core_m, core_result;
    logic [CNT_W-1:0] last_cycles;

    mont_sched #(.NW(NW), .NREQ(NREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_if          (bus),
        .core_start    (core_start),
        .core_a        (core_a),
        .core_b        (core_b),
        .core_m        (core_m),
        .core_out_read (core_out_read),
        .core_result   (core_result),
        .core_done     (core_done),
        .busy          (busy),
        .last_cycles   (last_cycles)
    );

    // Behavioural core: done rises lat cycles after the ISSUE cycle.
    int          lat        = 5;
    int          rem        = 0;
    logic        model_done = 1'b0;
    logic        stale_done = 1'b0;
    logic [NW-1:0] model_res = '0;
    assign core_done   = model_done | stale_done;
    assign core_result = model_res;

    always @(posedge clk) begin
        if (core_start) begin
            rem       <= lat - 1;
            model_res <= (core_a * core_b) % core_m;
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) model_done <= 1'b1;
        end
        if (core_out_read) model_done <= 1'b0;
    end

    // Monitors
    int   cyc = 0, n_start = 0, n_read = 0, done_cyc = 0, read_cyc = 0;
    logic prev_done = 1'b0;
    logic [NREQ-1:0] gnt_q[$];
    logic [NREQ-1:0] rspv_q[$];
    logic [NW-1:0]   rsp_q[$];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_done <= core_done;
        if (core_start) n_start <= n_start + 1;
        if (core_out_read) begin
            n_read   <= n_read + 1;
            read_cyc <= cyc;
        end
        if (core_done && !prev_done) done_cyc <= cyc;
        if (|(bus.req_valid & bus.req_ready)) gnt_q.push_back(bus.req_valid & bus.req_ready);
        if (|(bus.rsp_valid & bus.rsp_ready)) begin
            rsp_q.push_back(bus.rsp_data);
            rspv_q.push_back(bus.rsp_valid);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req_job(input int p, input logic [NW-1:0] a, input logic [NW-1:0] b,
                           input logic [NW-1:0] m, output bit ok);
        bus.req_a[p*NW +: NW] = a;
        bus.req_b[p*NW +: NW] = b;
        bus.m_cfg             = m;
        bus.req_valid[p]      = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.req_ready[p]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid[p] = 1'b0;
        $display("job port=%0d a=%0d b=%0d m=%0d granted=%0d", p, a, b, m, ok);
    endtask

    task automatic wait_rsp(input int p, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rsp_valid[p]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        $display("rsp port=%0d seen=%0d data=%0h last_cycles=%0d", p, ok, bus.rsp_data, last_cycles);
    endtask

    task automatic ack(input int p);
        bus.rsp_ready[p] = 1'b1;
        @(negedge clk);
        bus.rsp_ready[p] = 1'b0;
    endtask

    initial begin
        bit ok;
        int g0, q0, s0, r0, bad;
        bit saw;

        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.m_cfg     = '0;
        bus.rsp_ready = '0;

        // Reset state (requests held high to show no grant under reset)
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_out_read", core_out_read, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_last_cycles", last_cycles, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_m", core_m, 0);
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single job: 3*5 mod 7 = 1, latency 200
        lat = 200;
        g0 = gnt_q.size(); s0 = n_start; r0 = n_read;
        req_job(0, 3, 5, 7, ok);
        check("single_granted", ok, 1);
        check("single_start", core_start, 1);
        check("single_busy", busy, 1);
        check("single_core_a", core_a, 3);
        check("single_core_b", core_b, 5);
        check("single_core_m", core_m, 7);
        wait_rsp(0, 400, ok);
        check("single_rsp_seen", ok, 1);
        check("single_rsp_valid", bus.rsp_valid, 2'b01);
        check("single_rsp_data", bus.rsp_data, 1);
        check("single_last_cycles", last_cycles, 200);
        check("single_start_cnt", n_start - s0, 1);
        check("single_read_cnt", n_read - r0, 1);
        check("single_read_after_done", read_cyc - done_cyc, 1);
        check("single_grant_vec", gnt_q[g0], 2'b01);
        ack(0);
        #1;
        check("single_idle_busy", busy, 0);
        check("single_idle_rsp", bus.rsp_valid, 0);
        @(negedge clk);

        // Contention after reset: expect 0,1,0,1
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 5;
        bus.m_cfg        = 11;
        bus.req_a[0 +: NW] = 3;  bus.req_b[0 +: NW] = 4;   // 12 mod 11 = 1
        bus.req_a[NW +: NW] = 6; bus.req_b[NW +: NW] = 7;  // 42 mod 11 = 9
        bus.rsp_ready = 2'b11;
        g0 = gnt_q.size(); q0 = rsp_q.size();
        bus.req_valid = 2'b11;
        for (int i = 0; i < 200 && (gnt_q.size() - g0) < 4; i++) @(negedge clk);
        bus.req_valid = 2'b00;
        for (int i = 0; i < 200 && (rsp_q.size() - q0) < 4; i++) @(negedge clk);
        check("rr_rsp_count", rsp_q.size() - q0, 4);
        for (int i = 0; i < 4; i++) begin
            logic [NREQ-1:0] ev;
            ev = (i % 2 == 1) ? 2'b10 : 2'b01;
            if (gnt_q.size() > g0 + i) check($sformatf("rr_grant%0d", i), gnt_q[g0+i], ev);
            else check($sformatf("rr_grant%0d_missing", i), 0, ev);
            if (rsp_q.size() > q0 + i) begin
                check($sformatf("rr_rspv%0d", i), rspv_q[q0+i], ev);
                check($sformatf("rr_data%0d", i), rsp_q[q0+i], (i % 2 == 1) ? 9 : 1);
            end
            $display("rr step=%0d expected_port_vec=%b", i, ev);
        end

        // Only port1 requesting while port0 holds priority
        g0 = gnt_q.size(); q0 = rsp_q.size();
        req_job(1, 2, 5, 11, ok);   // 10 mod 11 = 10
        check("solo1_granted", ok, 1);
        for (int i = 0; i < 50 && rsp_q.size() == q0; i++) @(negedge clk);
        check("solo1_grant_vec", gnt_q[g0], 2'b10);
        check("solo1_rsp_count", rsp_q.size() - q0, 1);
        if (rsp_q.size() > q0) check("solo1_data", rsp_q[q0], 10);
        bus.rsp_ready = 2'b00;
        @(negedge clk);

        // Backpressure: port0 result held 50 cycles, port1 waiting
        bus.m_cfg = 13;
        req_job(0, 2, 9, 13, ok);   // 18 mod 13 = 5
        bus.req_a[NW +: NW] = 1;
        bus.req_b[NW +: NW] = 2;    // 2 mod 13 = 2
        bus.req_valid[1] = 1'b1;
        bus.rsp_ready[1] = 1'b1;    // must be ignored
        wait_rsp(0, 50, ok);
        check("bp_rsp_seen", ok, 1);
        s0 = n_start; bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.rsp_data !== 5 || bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b01) bad++;
        end
        check("bp_stable_violations", bad, 0);
        check("bp_no_start", n_start - s0, 0);
        check("bp_rsp_data", bus.rsp_data, 5);
        g0 = gnt_q.size(); q0 = rsp_q.size();
        ack(0);
        for (int i = 0; i < 20 && gnt_q.size() == g0; i++) @(negedge clk);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        for (int i = 0; i < 50 && (rsp_q.size() - q0) < 2; i++) @(negedge clk);
        check("bp_rsp_count", rsp_q.size() - q0, 2);
        if (gnt_q.size() > g0) check("bp_next_grant", gnt_q[g0], 2'b10);
        if (rsp_q.size() > q0 + 1) begin
            check("bp_data0", rsp_q[q0], 5);
            check("bp_data1", rsp_q[q0+1], 2);
        end
        bus.rsp_ready = 2'b00;
        @(negedge clk);

        // Stale done in IDLE with a pending request
        r0 = n_read; g0 = gnt_q.size();
        bus.m_cfg = 9;
        bus.req_a[0 +: NW] = 4;
        bus.req_b[0 +: NW] = 4;     // 16 mod 9 = 7
        stale_done = 1'b1;
        bus.req_valid[0] = 1'b1;
        #1;
        check("stale_no_ready", bus.req_ready, 2'b00);
        @(negedge clk);
        check("stale_flush_read", core_out_read, 1);
        check("stale_no_grant", gnt_q.size() - g0, 0);
        stale_done = 1'b0;
        @(negedge clk);
        #1;
        check("stale_grant_after", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        check("stale_read_cnt", n_read - r0, 1);
        wait_rsp(0, 50, ok);
        check("stale_rsp_seen", ok, 1);
        check("stale_rsp_data", bus.rsp_data, 7);
        ack(0);

        // Reset during WAIT, then the abandoned job's done arrives
        lat = 40;
        bus.m_cfg = 6;
        req_job(0, 5, 5, 6, ok);
        repeat (10) @(negedge clk);
        s0 = n_start; r0 = n_read;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        saw = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (|bus.rsp_valid) saw = 1'b1;
        end
        check("mid_rst_no_rsp", saw, 0);
        check("mid_rst_flush_reads", n_read - r0, 1);
        check("mid_rst_no_start", n_start - s0, 0);
        check("mid_rst_idle", busy, 0);
        g0 = gnt_q.size();
        bus.m_cfg = 4;
        req_job(1, 2, 3, 4, ok);    // 6 mod 4 = 2
        wait_rsp(1, 100, ok);
        check("mid_rst_next_seen", ok, 1);
        check("mid_rst_next_grant", gnt_q[g0], 2'b10);
        check("mid_rst_next_data", bus.rsp_data, 2);
        ack(1);

        // Latency counter saturation
        lat = 70000;
        bus.m_cfg = 3;
        req_job(0, 1, 1, 3, ok);
        wait_rsp(0, 70100, ok);
        check("sat_rsp_seen", ok, 1);
        check("sat_last_cycles", last_cycles, 16'hFFFF);
        check("sat_rsp_data", bus.rsp_data, 1);
        ack(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
